// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - arbiter sharing one up/down counter between two requesters
module counter_scheduler #(
    parameter int W       = 5,
    parameter int TIMEOUT = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         dir0,
    input  logic [W-1:0] tgt0,
    input  logic         req1,
    input  logic         dir1,
    input  logic [W-1:0] tgt1,
    input  logic [W-1:0] cnt_val,
    output logic         mode,
    output logic         cnt_clr,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         busy
);

    // RUN-cycle counter only needs to reach TIMEOUT-1
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic            owner;
    logic            last_owner;
    logic [W-1:0]    tgt_q;
    logic [CW-1:0]   cyc;
    logic            pick;
    logic [1:0]      owner_hot;

    // Round-robin choice: on a tie the requester that did not own the last session wins
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_owner;
        end else begin
            pick = req1;
        end
    end

    assign owner_hot = owner ? 2'b10 : 2'b01;

    // Session FSM; every output is a register updated here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode       <= 1'b1;
            cnt_clr    <= 1'b0;
            gnt        <= 2'b00;
            done       <= 2'b00;
            err        <= 1'b0;
            result     <= '0;
            busy       <= 1'b0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            tgt_q      <= '0;
            cyc        <= '0;
        end else begin
            gnt     <= 2'b00;
            done    <= 2'b00;
            cnt_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= pick;
                        mode    <= pick ? dir1 : dir0;
                        tgt_q   <= pick ? tgt1 : tgt0;
                        gnt     <= pick ? 2'b10 : 2'b01;
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    cyc   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (cnt_val == tgt_q) begin
                        result <= cnt_val;
                        err    <= 1'b0;
                        done   <= owner_hot;
                        state  <= DONE;
                    end else if (cyc == CYC_LAST) begin
                        result <= cnt_val;
                        err    <= 1'b1;
                        done   <= owner_hot;
                        state  <= DONE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DONE: begin
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// tb/tb_counter_scheduler.sv - directed self-checking bench for counter_scheduler
module tb_counter_scheduler;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, dir0 = 1'b1, req1 = 1'b0, dir1 = 1'b1;
    logic [W-1:0] tgt0 = '0, tgt1 = '0;
    logic [W-1:0] cnt_val;
    logic         mode, cnt_clr, err, busy;
    logic [1:0]   gnt, done;
    logic [W-1:0] result;

    logic [W-1:0] cnt_q = '0;
    logic [W-1:0] hold_val = '0;
    logic         hold = 1'b0;

    int checks = 0;
    int failures = 0;

    counter_scheduler #(.W(W), .TIMEOUT(34)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .dir0(dir0), .tgt0(tgt0),
        .req1(req1), .dir1(dir1), .tgt1(tgt1),
        .cnt_val(cnt_val), .mode(mode), .cnt_clr(cnt_clr),
        .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bench model of the shared up/down counter with synchronous clear
    always @(posedge clk) begin
        if (cnt_clr) cnt_q <= '0;
        else if (mode) cnt_q <= cnt_q + 1'b1;
        else cnt_q <= cnt_q - 1'b1;
    end

    assign cnt_val = hold ? hold_val : cnt_q;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        step;
        step;
        checks++;
        if ({mode, cnt_clr, gnt, done, err, result, busy} !== {1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {mode, cnt_clr, gnt, done, err, result, busy},
                     {1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0});
        end
        rst = 1'b1;
        step;
    endtask

    task automatic test_count_up;
        req0 = 1'b1; dir0 = 1'b1; tgt0 = 5'd3;
        step;
        checks++;
        if ({gnt, cnt_clr, mode, busy} !== 5'b01111) begin
            failures++;
            $display("FAIL up_clr got=%b exp=%b", {gnt, cnt_clr, mode, busy}, 5'b01111);
        end
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            checks++;
            if (cnt_val !== W'(i) || done !== 2'b00 || busy !== 1'b1 || cnt_clr !== 1'b0) begin
                failures++;
                $display("FAIL up_run%0d got cnt=%0d done=%b busy=%b clr=%b exp cnt=%0d done=00 busy=1 clr=0",
                         i, cnt_val, done, busy, cnt_clr, i);
            end
        end
        step;
        checks++;
        if ({done, err, result} !== {2'b01, 1'b0, 5'd3}) begin
            failures++;
            $display("FAIL up_done got done=%b err=%b result=%0d exp done=01 err=0 result=3", done, err, result);
        end
        step;
        checks++;
        if (busy !== 1'b0 || done !== 2'b00) begin
            failures++;
            $display("FAIL up_idle got busy=%b done=%b exp busy=0 done=00", busy, done);
        end
    endtask

    task automatic test_count_down;
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 5'd0; exp_seq[1] = 5'd31; exp_seq[2] = 5'd30;
        req1 = 1'b1; dir1 = 1'b0; tgt1 = 5'd30;
        step;
        checks++;
        if ({gnt, cnt_clr, mode} !== 4'b1010) begin
            failures++;
            $display("FAIL down_clr got=%b exp=%b", {gnt, cnt_clr, mode}, 4'b1010);
        end
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (cnt_val !== exp_seq[i] || mode !== 1'b0 || done !== 2'b00) begin
                failures++;
                $display("FAIL down_run%0d got cnt=%0d mode=%b done=%b exp cnt=%0d mode=0 done=00",
                         i, cnt_val, mode, done, exp_seq[i]);
            end
        end
        step;
        checks++;
        if ({done, err, result, mode} !== {2'b10, 1'b0, 5'd30, 1'b0}) begin
            failures++;
            $display("FAIL down_done got done=%b err=%b result=%0d mode=%b exp done=10 err=0 result=30 mode=0",
                     done, err, result, mode);
        end
        step;
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_gnt [4];
        int n = 0;
        int idle_run = 0;
        logic prev_busy = 1'b0;
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        req0 = 1'b1; dir0 = 1'b1; tgt0 = 5'd2;
        req1 = 1'b1; dir1 = 1'b1; tgt1 = 5'd1;
        for (int c = 0; c < 40; c++) begin
            step;
            if (gnt !== 2'b00) begin
                checks++;
                if (n >= 4 || gnt !== exp_gnt[n]) begin
                    failures++;
                    $display("FAIL b2b_order%0d got=%b exp=%b", n, gnt, (n < 4) ? exp_gnt[n] : 2'b00);
                end
                checks++;
                if (prev_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_overlap%0d got prev_busy=%b exp=0", n, prev_busy);
                end
                if (n > 0) begin
                    checks++;
                    if (idle_run !== 1) begin
                        failures++;
                        $display("FAIL b2b_gap%0d got idle_cycles=%0d exp=1", n, idle_run);
                    end
                end
                n++;
                idle_run = 0;
                if (n == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end else if (busy === 1'b0) begin
                idle_run++;
            end else begin
                idle_run = 0;
            end
            prev_busy = busy;
        end
        checks++;
        if (n !== 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count got grants=%0d busy=%b exp grants=4 busy=0", n, busy);
        end
    endtask

    task automatic test_zero_target;
        for (int d = 0; d < 2; d++) begin
            req0 = 1'b1; dir0 = d[0]; tgt0 = 5'd0;
            step;
            checks++;
            if (gnt !== 2'b01 || mode !== d[0]) begin
                failures++;
                $display("FAIL zero_clr dir=%0d got gnt=%b mode=%b exp gnt=01 mode=%0d", d, gnt, mode, d);
            end
            req0 = 1'b0;
            step;
            step;
            checks++;
            if ({done, err, result} !== {2'b01, 1'b0, 5'd0}) begin
                failures++;
                $display("FAIL zero_done dir=%0d got done=%b err=%b result=%0d exp done=01 err=0 result=0",
                         d, done, err, result);
            end
            step;
        end
    endtask

    task automatic test_timeout;
        int bad = 0;
        hold = 1'b1; hold_val = 5'd5;
        req0 = 1'b1; dir0 = 1'b1; tgt0 = 5'd7;
        step;
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL to_clr got=%b exp=01", gnt);
        end
        req0 = 1'b0;
        for (int i = 0; i < 34; i++) begin
            step;
            if (done !== 2'b00) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL to_early got early_done_cycles=%0d exp=0", bad);
        end
        step;
        checks++;
        if ({done, err, result} !== {2'b01, 1'b1, 5'd5}) begin
            failures++;
            $display("FAIL to_done got done=%b err=%b result=%0d exp done=01 err=1 result=5", done, err, result);
        end
        step;
        hold = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int bad = 0;
        req0 = 1'b1; dir0 = 1'b1; tgt0 = 5'd20;
        step;
        req0 = 1'b0;
        step;
        step;
        step;
        rst = 1'b0;
        #1;
        checks++;
        if ({mode, cnt_clr, gnt, done, err, result, busy} !== {1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b exp=%b", {mode, cnt_clr, gnt, done, err, result, busy},
                     {1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            step;
            if (done !== 2'b00 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rstmid_quiet got bad_cycles=%0d exp=0", bad);
        end
        rst = 1'b1;
        req1 = 1'b1; dir1 = 1'b1; tgt1 = 5'd2;
        step;
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_gnt got=%b exp=10", gnt);
        end
        req1 = 1'b0;
        step;
        step;
        step;
        step;
        checks++;
        if ({done, err, result} !== {2'b10, 1'b0, 5'd2}) begin
            failures++;
            $display("FAIL rstmid_done got done=%b err=%b result=%0d exp done=10 err=0 result=2", done, err, result);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_count_down;
        test_back_to_back;
        test_zero_target;
        test_timeout;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
